// File: rtl/mem_arbiter_n_if.sv
// Memory handshake bundle (req/we/addr/wdata/rdata/ready) with N request lanes.
// Lane i occupies addr[i*ADDR_W +: ADDR_W] and wdata[i*DATA_W +: DATA_W]; rdata is shared.
// Use N = NUM_MASTERS on the master side of the arbiter and N = 1 on the slave side.
interface mem_arbiter_n_if #(
  parameter int unsigned N      = 1,
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);
  logic [N-1:0]        req;
  logic [N-1:0]        we;
  logic [N*ADDR_W-1:0] addr;
  logic [N*DATA_W-1:0] wdata;
  logic [DATA_W-1:0]   rdata;
  logic [N-1:0]        ready;

  // Requester side: issues commands, receives completion.
  modport master (output req, we, addr, wdata, input rdata, ready);
  // Responder side: accepts commands, returns completion.
  modport slave (input req, we, addr, wdata, output rdata, ready);
endinterface

// File: rtl/mem_arbiter_n.sv
// N-master to one-slave memory arbiter with fixed-priority or round-robin selection,
// a latched command held for the whole transaction, and an optional slave-timeout watchdog.
module mem_arbiter_n #(
  parameter int unsigned NUM_MASTERS    = 4,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ARB_MODE       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 0,
  parameter logic [31:0] ERR_RDATA      = 32'hDEADBEEF,
  localparam int unsigned GW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  mem_arbiter_n_if.slave  m_bus,
  mem_arbiter_n_if.master s_bus,
  output logic [GW-1:0]   grant_id_o,
  output logic            busy_o,
  output logic            err_o,
  output logic [7:0]      err_count_o
);

  localparam int unsigned TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [DATA_W-1:0] ErrData = DATA_W'(ERR_RDATA);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e              state_q, state_d;
  logic [GW-1:0]       grant_q, grant_d;
  logic [GW-1:0]       last_q, last_d;
  logic                s_we_q, s_we_d;
  logic [ADDR_W-1:0]   s_addr_q, s_addr_d;
  logic [DATA_W-1:0]   s_wdata_q, s_wdata_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [7:0]          err_cnt_q, err_cnt_d;

  logic [GW-1:0]       winner;
  logic                found;
  int unsigned         rr_idx;
  logic                timeout_hit;
  logic [NUM_MASTERS-1:0] m_ready;
  logic [DATA_W-1:0]   m_rdata;
  logic                err;

  // Winner selection: lowest index in fixed mode, next after last grant in round-robin.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    rr_idx = 0;
    if (ARB_MODE == 0) begin
      for (int i = 0; i < NUM_MASTERS; i++) begin
        if (!found && m_bus.req[i]) begin
          winner = GW'(i);
          found  = 1'b1;
        end
      end
    end else begin
      for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
        rr_idx = (32'(last_q) + i) % NUM_MASTERS;
        if (!found && m_bus.req[rr_idx]) begin
          winner = GW'(rr_idx);
          found  = 1'b1;
        end
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (timer_q == TW'(TIMEOUT_CYCLES));

  // Next-state and completion outputs; a real s_ready beats a simultaneous timeout.
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    s_we_d    = s_we_q;
    s_addr_d  = s_addr_q;
    s_wdata_d = s_wdata_q;
    timer_d   = timer_q;
    err_cnt_d = err_cnt_q;
    m_ready   = '0;
    m_rdata   = '0;
    err       = 1'b0;
    case (state_q)
      StIdle: begin
        if (found) begin
          state_d   = StBusy;
          grant_d   = winner;
          last_d    = winner;
          s_we_d    = m_bus.we[winner];
          s_addr_d  = m_bus.addr[winner*ADDR_W +: ADDR_W];
          s_wdata_d = m_bus.wdata[winner*DATA_W +: DATA_W];
          timer_d   = (TIMEOUT_CYCLES != 0) ? TW'(1) : '0;
        end
      end
      StBusy: begin
        if (s_bus.ready[0]) begin
          m_ready[grant_q] = 1'b1;
          m_rdata          = s_bus.rdata;
          state_d          = StIdle;
          timer_d          = '0;
        end else if (timeout_hit) begin
          m_ready[grant_q] = 1'b1;
          m_rdata          = ErrData;
          err              = 1'b1;
          if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
          state_d          = StIdle;
          timer_d          = '0;
        end else if (TIMEOUT_CYCLES != 0) begin
          timer_d = timer_q + TW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and latched-command registers; reset aborts any transaction in flight.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      grant_q   <= '0;
      last_q    <= GW'(NUM_MASTERS - 1);
      s_we_q    <= 1'b0;
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      timer_q   <= '0;
      err_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      s_we_q    <= s_we_d;
      s_addr_q  <= s_addr_d;
      s_wdata_q <= s_wdata_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  assign s_bus.req   = (state_q == StBusy);
  assign s_bus.we    = s_we_q;
  assign s_bus.addr  = s_addr_q;
  assign s_bus.wdata = s_wdata_q;

  assign m_bus.ready = m_ready;
  assign m_bus.rdata = m_rdata;

  assign grant_id_o  = grant_q;
  assign busy_o      = (state_q == StBusy);
  assign err_o       = err;
  assign err_count_o = err_cnt_q;

endmodule
